// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields into MIPS words
// and buffers them in a small FIFO for the control_unit inst port.
module inst_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err_illegal,
  output logic [CNT_W-1:0] inst_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   occ;
  logic [31:0]   word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic          empty;

  logic cls_r, cls_ld, cls_st, cls_beq, cls_addi, cls_j;

  assign cls_r    = (in_class == 4'd0);
  assign cls_ld   = (in_class == 4'd1);
  assign cls_st   = (in_class == 4'd2);
  assign cls_beq  = (in_class == 4'd3);
  assign cls_addi = (in_class == 4'd4);
  assign cls_j    = (in_class == 4'd5);
  assign legal    = (in_class < 4'd6);

  assign empty     = (occ == '0);
  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = !empty;
  assign out_inst  = empty ? 32'h0 : mem[rd_ptr];

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  // Field packing per instruction class; illegal classes yield zero.
  always_comb begin
    word = 32'h0;
    unique case (1'b1)
      cls_r:    word = {6'h00, in_rs, in_rt, in_rd,
                        in_shamt, in_funct};
      cls_ld:   word = {6'h23, in_rs, in_rt, in_imm};
      cls_st:   word = {6'h2B, in_rs, in_rt, in_imm};
      cls_beq:  word = {6'h04, in_rs, in_rt, in_imm};
      cls_addi: word = {6'h08, in_rs, in_rt, in_imm};
      cls_j:    word = {6'h02, in_target};
      default:  word = 32'h0;
    endcase
  end

  // FIFO storage; entries cleared on reset so no stale word survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // Illegal-class pulse and wrapping count of legal pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      inst_count  <= '0;
    end else begin
      err_illegal <= accept && !legal;
      if (push) inst_count <= inst_count + 1'b1;
    end
  end

endmodule
